// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial add/subtract controller.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter only needs to reach WIDTH-1; keep at least one bit for WIDTH = 1.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Start/done handshake, operands and result flags of the serial adder controller.
interface serial_adder_ctrl_if #(parameter int WIDTH = 8);

    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, overflow
    );

endinterface

// File: rtl/serial_adder_ctrl_full_adder.sv
// One-bit full adder cell, the only arithmetic element of the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: shares one full_adder over WIDTH bits, LSB first.
// state | meaning
// IDLE  | waiting for start; operands captured on accept
// RUN   | one operand bit per clock through the full adder
// DONE  | one-cycle done pulse, flags valid; back to IDLE
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                rst_n,
    serial_adder_ctrl_if.slave bus
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             cout_r;
    logic             ovf_r;
    logic             fa_s;
    logic             fa_co;
    logic             last_bit;

    assign last_bit = (cnt == LAST);

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == RUN);
        bus.done = (state == DONE);
    end

    // Subtraction is a + ~b + 1, so the inversion and the forced carry happen at capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh  <= bus.a;
                        b_sh  <= bus.sub ? ~bus.b : bus.b;
                        carry <= bus.sub | bus.cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    sum_sh <= (sum_sh >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= fa_co;
                    if (last_bit) begin
                        // carry still holds the carry into the MSB here
                        cout_r <= fa_co;
                        ovf_r  <= carry ^ fa_co;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sum      = sum_sh;
    assign bus.cout     = cout_r;
    assign bus.overflow = ovf_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and model-checked bench for serial_adder_ctrl at WIDTH = 8, 1 and 13.
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl_if #(.WIDTH(8))  b8 ();
    serial_adder_ctrl_if #(.WIDTH(1))  b1 ();
    serial_adder_ctrl_if #(.WIDTH(13)) b13 ();

    serial_adder_ctrl #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(b8));
    serial_adder_ctrl #(.WIDTH(1))  u1  (.clk(clk), .rst_n(rst_n), .bus(b1));
    serial_adder_ctrl #(.WIDTH(13)) u13 (.clk(clk), .rst_n(rst_n), .bus(b13));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Returns {overflow, cout, sum}; overflow from operand/result signs.
    function automatic logic [33:0] model(input int w, input logic s, input logic [31:0] x,
                                          input logic [31:0] y, input logic ci);
        logic [31:0] mask, bb, res;
        logic [63:0] full;
        logic        co, ov;
        mask = (32'd1 << w) - 32'd1;
        bb   = s ? (~y & mask) : y;
        full = 64'(x) + 64'(bb) + 64'(s ? 1'b1 : ci);
        res  = full[31:0] & mask;
        co   = full[w];
        ov   = (x[w-1] == bb[w-1]) && (res[w-1] != x[w-1]);
        return {ov, co, res};
    endfunction

    // Called #1 after an edge with the DUT idle; leaves it idle again.
    task automatic op8(input string tag, input logic s, input logic [7:0] x, input logic [7:0] y,
                       input logic ci, input logic [7:0] e_sum, input logic e_co,
                       input logic e_ov, input bit poke);
        int lat, nbusy;
        b8.start = 1'b1; b8.sub = s; b8.a = x; b8.b = y; b8.cin = ci;
        @(posedge clk); #1;
        b8.start = 1'b0; b8.a = ~x; b8.b = ~y; b8.cin = ~ci;
        lat = 0; nbusy = 0;
        while (!b8.done && lat < 40) begin
            if (b8.busy) nbusy++;
            b8.start = poke && (lat == 3 || lat == 6);
            if (b8.start) begin b8.a = 8'd1; b8.b = 8'd1; b8.sub = 1'b0; end
            @(posedge clk); #1;
            lat++;
        end
        b8.start = 1'b0;
        chk({tag, "_lat"}, lat, 8);
        chk({tag, "_busy"}, nbusy, 8);
        chk({tag, "_sum"}, b8.sum, e_sum);
        chk({tag, "_cout"}, b8.cout, e_co);
        chk({tag, "_ovf"}, b8.overflow, e_ov);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, b8.done, 0);
        chk({tag, "_hold"}, b8.sum, e_sum);
    endtask

    task automatic op13(input logic s, input logic [12:0] x, input logic [12:0] y, input logic ci);
        int lat;
        logic [33:0] m;
        m = model(13, s, 32'(x), 32'(y), ci);
        b13.start = 1'b1; b13.sub = s; b13.a = x; b13.b = y; b13.cin = ci;
        @(posedge clk); #1;
        b13.start = 1'b0; b13.a = ~x;
        lat = 0;
        while (!b13.done && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("w13_lat", lat, 13);
        chk("w13_sum", b13.sum, m[31:0]);
        chk("w13_cout", b13.cout, m[32]);
        chk("w13_ovf", b13.overflow, m[33]);
        @(posedge clk); #1;
    endtask

    task automatic op1(input logic x, input logic y, input logic ci,
                       input logic e_sum, input logic e_co, input logic e_ov);
        int lat;
        b1.start = 1'b1; b1.sub = 1'b0; b1.a = x; b1.b = y; b1.cin = ci;
        @(posedge clk); #1;
        b1.start = 1'b0;
        lat = 0;
        while (!b1.done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("w1_lat", lat, 1);
        chk("w1_sum", b1.sum, e_sum);
        chk("w1_cout", b1.cout, e_co);
        chk("w1_ovf", b1.overflow, e_ov);
        @(posedge clk); #1;
    endtask

    initial begin
        int first, second, edges, lat;
        bit seen_done;
        logic [33:0] m;
        logic [7:0] x8, y8;
        logic s, ci;
        b8.start = 0;  b8.sub = 0;  b8.a = 0;  b8.b = 0;  b8.cin = 0;
        b1.start = 0;  b1.sub = 0;  b1.a = 0;  b1.b = 0;  b1.cin = 0;
        b13.start = 0; b13.sub = 0; b13.a = 0; b13.b = 0; b13.cin = 0;

        #2;
        chk("rst_busy", b8.busy, 0);
        chk("rst_done", b8.done, 0);
        chk("rst_sum", b8.sum, 0);
        chk("rst_cout", b8.cout, 0);
        chk("rst_ovf", b8.overflow, 0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        op8("add_200_100", 0, 8'd200, 8'd100, 0, 8'd44, 1, 0, 0);
        op8("add_127_1", 0, 8'd127, 8'd1, 0, 8'd128, 0, 1, 0);
        op8("add_255_0_c", 0, 8'd255, 8'd0, 1, 8'd0, 1, 0, 0);
        op8("sub_5_7", 1, 8'd5, 8'd7, 0, 8'd254, 0, 0, 0);
        op8("sub_7_5", 1, 8'd7, 8'd5, 1, 8'd2, 1, 0, 0);
        op8("sub_128_1", 1, 8'd128, 8'd1, 0, 8'd127, 1, 1, 0);

        // abort after four bits of 200 + 100
        b8.start = 1'b1; b8.sub = 0; b8.a = 8'd200; b8.b = 8'd100; b8.cin = 0;
        @(posedge clk); #1;
        b8.start = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (b8.done) seen_done = 1;
        end
        rst_n = 1'b0;
        #1;
        chk("abort_busy", b8.busy, 0);
        chk("abort_done", b8.done, 0);
        chk("abort_sum", b8.sum, 0);
        chk("abort_cout", b8.cout, 0);
        chk("abort_ovf", b8.overflow, 0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (b8.done) seen_done = 1;
        end
        chk("abort_no_done", seen_done, 0);
        op8("add_3_4", 0, 8'd3, 8'd4, 0, 8'd7, 0, 0, 0);

        op8("ignore_start", 0, 8'd200, 8'd100, 0, 8'd44, 1, 0, 1);

        // start held high: DONE returns to IDLE, which re-accepts on the next edge
        b8.start = 1'b1; b8.sub = 0; b8.a = 8'd10; b8.b = 8'd20; b8.cin = 0;
        first = -1; second = -1; edges = 0;
        while (second < 0 && edges < 60) begin
            @(posedge clk); #1;
            edges++;
            if (b8.done) begin
                chk("b2b_sum", b8.sum, 30);
                if (first < 0) first = edges;
                else begin second = edges; b8.start = 1'b0; end
            end
        end
        b8.start = 1'b0;
        chk("b2b_first", first, 9);
        chk("b2b_gap", second - first, 10);
        @(posedge clk); #1;

        op1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        op1(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        op1(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            x8 = 8'($urandom); y8 = 8'($urandom);
            s = 1'($urandom); ci = 1'($urandom);
            m = model(8, s, 32'(x8), 32'(y8), ci);
            op8("rnd8", s, x8, y8, ci, m[7:0], m[32], m[33], 0);
        end
        for (int i = 0; i < 1000; i++) begin
            op13(1'($urandom), 13'($urandom), 13'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
